load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store unit sitting between the core datapath and data memory.
- Store data comes from the register file second read port; extended load data goes back to the register file write-data mux.
- Performs RV32I size/sign handling: byte enables, store-data replication, load extraction and extension.
- Runs a request/ready handshake with memory and stalls the core until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent waiting for mem_ready_i before aborting with error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core requests a memory access this instruction
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (rs2 from register file)
- core_rd_o  out  32  extended load data to register-file write mux
- core_stall_o  out  1  core must hold PC and inputs while high
- lsu_err_o  out  1  access aborted (misaligned, illegal size, timeout); valid while stall is low
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wd_o  out  32  replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completed the access (valid only while mem_req_o high)

Behaviour:
- Reset (async, rst_ni=0):
  - state IDLE; all latched registers cleared; timeout counter 0.
  - Outputs: core_rd_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0, lsu_err_o=0.
  - core_stall_o = core_req_i (combinational), so it is 0 unless a request is present.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If core_req_i=1, latch we, size, addr and wd.
  - Illegal size (011/110/111), or misalignment (H with addr[0]=1, W with addr[1:0]!=0), goes straight to DONE with err=1 and no memory request.
  - Any other request goes to BUSY.
- BUSY:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are driven from the latched values.
  - Counter increments each cycle.
  - mem_ready_i=1: capture extended load data into core_rd_o (stores leave core_rd_o unchanged), err=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES (nonzero) without ready: err=1, go to DONE, mem_req_o drops.
- DONE: lasts one cycle, then goes to IDLE; lsu_err_o holds the DONE value until the next access enters DONE.
- core_stall_o = core_req_i && (state != DONE).
  - Minimum stall is 2 cycles: request cycle plus first BUSY cycle with ready=1. Stall releases in DONE, where core_rd_o is valid.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load extraction:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Boundary conditions:
  - core_req_i dropping while BUSY: access still completes; result is latched but ignored.
  - mem_ready_i while IDLE or DONE: ignored.
  - A new request present in the DONE cycle is not accepted until the following IDLE cycle. The core advances in DONE, so this is a new instruction.
  - Reset mid-BUSY: mem_req_o drops immediately and the pending access is abandoned.
- Timeout counter is wide enough for TIMEOUT_CYCLES and is cleared on entering BUSY.

Test Plan:
- Store byte: SB, addr=0x1003, wd=0x000000A5, ready on first BUSY cycle -> mem_be_o=4'b1000, mem_wd_o=0xA5A5A5A5, mem_addr_o=0x1000, stall high 2 cycles, lsu_err_o=0.
- Load byte signed/unsigned: mem_rd_i=0x80FF7F01, addr=0x2002 -> LB gives core_rd_o=0xFFFFFFFF, LBU gives 0x000000FF. LH at 0x2002 gives 0xFFFF80FF; LHU gives 0x000080FF.
- Wait states: LW at 0x3000, ready after 5 BUSY cycles, mem_rd_i=0x12345678 -> stall high 6 cycles, core_rd_o=0x12345678 in DONE.
- Misaligned/illegal: LW addr=0x3002, then size=3'b011 -> no mem_req_o, stall 1 cycle, lsu_err_o=1.
- Timeout: TIMEOUT_CYCLES=4, never assert ready -> mem_req_o high 4 cycles, then DONE with lsu_err_o=1, back to IDLE.
- Reset mid-op: assert rst_ni=0 during BUSY -> mem_req_o and core_rd_o go to 0 asynchronously. After release, a fresh SW wd=0xDEADBEEF yields mem_be_o=4'b1111 and mem_wd_o=0xDEADBEEF.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store unit between the core
// datapath and data memory. It builds byte enables and replicated store data,
// extracts and sign/zero-extends load data, and holds the core stalled while
// the memory request/ready handshake is outstanding.
//
// Memory handshake: mem_req_o is high for every BUSY cycle. The memory
// completes the access by raising mem_ready_i in a cycle where mem_req_o is
// high. mem_ready_i seen while mem_req_o is low is ignored. The request
// attributes (we/be/addr/wd) stay constant for as long as mem_req_o is high.
`timescale 1ns/1ps

module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        lsu_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   // funct3 size encodings
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // Counter must hold TIMEOUT_CYCLES-1; with the timeout disabled a single
   // bit is kept so the declaration stays legal.
   localparam int unsigned CNT_W =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } lsu_state_e;

   lsu_state_e        state_q;
   logic              we_q;
   logic [2:0]        size_q;
   logic [31:0]       addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wd_q;
   logic              req_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rd_q;
   logic              err_q;

   // Request decode from the core inputs (only consumed in IDLE)
   logic              size_ok_d;
   logic              misal_d;
   logic              reject_d;
   logic [3:0]        be_d;
   logic [31:0]       wd_d;

   // Load extraction from the memory word using the latched request
   logic [7:0]        ld_byte_d;
   logic [15:0]       ld_half_d;
   logic [31:0]       ld_data_d;
   logic              timeout_hit_d;
   logic              finish_d;

   // Decode size legality, alignment, byte enables and store replication
   always_comb begin
      size_ok_d = 1'b0;
      misal_d   = 1'b0;
      be_d      = 4'b0000;
      wd_d      = core_wd_i;
      case (core_size_i)
         SZ_B, SZ_BU: begin
            size_ok_d = 1'b1;
            be_d      = 4'b0001 << core_addr_i[1:0];
            wd_d      = {4{core_wd_i[7:0]}};
         end
         SZ_H, SZ_HU: begin
            size_ok_d = 1'b1;
            misal_d   = core_addr_i[0];
            be_d      = 4'b0011 << core_addr_i[1:0];
            wd_d      = {2{core_wd_i[15:0]}};
         end
         SZ_W: begin
            size_ok_d = 1'b1;
            misal_d   = |core_addr_i[1:0];
            be_d      = 4'b1111;
            wd_d      = core_wd_i;
         end
         default: begin
            size_ok_d = 1'b0;
         end
      endcase
      reject_d = !size_ok_d || misal_d;
   end

   // Select the addressed byte/halfword of the read word and extend it
   always_comb begin
      ld_byte_d = mem_rd_i[7:0];
      case (addr_q[1:0])
         2'd0:    ld_byte_d = mem_rd_i[7:0];
         2'd1:    ld_byte_d = mem_rd_i[15:8];
         2'd2:    ld_byte_d = mem_rd_i[23:16];
         default: ld_byte_d = mem_rd_i[31:24];
      endcase
      ld_half_d = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      case (size_q)
         SZ_B:    ld_data_d = {{24{ld_byte_d[7]}}, ld_byte_d};
         SZ_BU:   ld_data_d = {24'h000000, ld_byte_d};
         SZ_H:    ld_data_d = {{16{ld_half_d[15]}}, ld_half_d};
         SZ_HU:   ld_data_d = {16'h0000, ld_half_d};
         default: ld_data_d = mem_rd_i;
      endcase
   end

   // Completion conditions for the BUSY state
   always_comb begin
      timeout_hit_d = TIMEOUT_EN && (cnt_q == CNT_LAST);
      finish_d      = mem_ready_i || timeout_hit_d;
   end

   // Control FSM with registered memory-side outputs and load result
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 3'b000;
         addr_q  <= 32'h0000_0000;
         be_q    <= 4'b0000;
         wd_q    <= 32'h0000_0000;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         rd_q    <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (core_req_i) begin
                  if (reject_d) begin
                     // Illegal or misaligned: report without touching memory
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     we_q    <= core_we_i;
                     size_q  <= core_size_i;
                     addr_q  <= core_addr_i;
                     be_q    <= be_d;
                     wd_q    <= wd_d;
                     req_q   <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               if (finish_d) begin
                  // Drop the request and clear its attributes on the way out
                  state_q <= S_DONE;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  be_q    <= 4'b0000;
                  wd_q    <= 32'h0000_0000;
                  addr_q  <= 32'h0000_0000;
                  size_q  <= 3'b000;
                  if (mem_ready_i) begin
                     err_q <= 1'b0;
                     if (!we_q) begin
                        rd_q <= ld_data_d;
                     end
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // Core advances here; any request now belongs to the next
               // instruction and is picked up in IDLE.
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The stall is released in DONE, where core_rd_o/lsu_err_o are valid
   always_comb begin
      core_stall_o = core_req_i && (state_q != S_DONE);
   end

   assign core_rd_o  = rd_q;
   assign lsu_err_o  = err_q;
   assign mem_req_o  = req_q;
   assign mem_we_o   = we_q;
   assign mem_be_o   = be_q;
   assign mem_addr_o = {addr_q[31:2], 2'b00};
   assign mem_wd_o   = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit. A second instance
// with a short timeout shares the stimulus and is only observed in the
// timeout scenario.
`timescale 1ns/1ps

module tb_load_store_unit;

   // ---------------- clock / reset ----------------
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        lsu_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;

   logic [31:0] to_core_rd_o;
   logic        to_core_stall_o;
   logic        to_lsu_err_o;
   logic        to_mem_req_o;
   logic        to_mem_we_o;
   logic [3:0]  to_mem_be_o;
   logic [31:0] to_mem_addr_o;
   logic [31:0] to_mem_wd_o;

   load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .lsu_err_o    (lsu_err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (to_core_rd_o),
      .core_stall_o (to_core_stall_o),
      .lsu_err_o    (to_lsu_err_o),
      .mem_req_o    (to_mem_req_o),
      .mem_we_o     (to_mem_we_o),
      .mem_be_o     (to_mem_be_o),
      .mem_addr_o   (to_mem_addr_o),
      .mem_wd_o     (to_mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Observations of the last access
   int          obs_stall;
   int          obs_req;
   logic [3:0]  obs_be;
   logic [31:0] obs_wd;
   logic [31:0] obs_addr;
   logic        obs_we;
   logic        obs_err;
   logic [31:0] obs_rd;

   // ---------------- driver tasks ----------------
   // Issue one access and act as memory: raise ready in BUSY cycle ready_at
   // (0 = never). Returns at the negedge of the first unstalled cycle.
   task automatic run_access(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int ready_at);
      int busy_n;
      bit done;
      busy_n    = 0;
      done      = 1'b0;
      obs_stall = 0;
      obs_req   = 0;
      obs_be    = 4'b0000;
      obs_wd    = 32'h0;
      obs_addr  = 32'h0;
      obs_we    = 1'b0;
      obs_err   = 1'bx;
      obs_rd    = 32'hx;
      @(posedge clk_i); #1;
      core_req_i  = 1'b1;
      core_we_i   = we;
      core_size_i = size;
      core_addr_i = addr;
      core_wd_i   = wd;
      mem_rd_i    = rdata;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) begin
            @(posedge clk_i); #1;
         end
         if (mem_req_o) busy_n++;
         mem_ready_i = mem_req_o && (busy_n == ready_at);
         @(negedge clk_i);
         if (mem_req_o) begin
            if (obs_req == 0) begin
               obs_be   = mem_be_o;
               obs_wd   = mem_wd_o;
               obs_addr = mem_addr_o;
               obs_we   = mem_we_o;
            end
            obs_req++;
         end
         if (core_stall_o) begin
            obs_stall++;
         end else begin
            done    = 1'b1;
            obs_err = lsu_err_o;
            obs_rd  = core_rd_o;
         end
      end
      core_req_i  = 1'b0;
      mem_ready_i = 1'b0;
      check_eq("access_completes", {31'b0, done}, 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int  to_req_n;
   bit  to_done;

   initial begin
      core_req_i  = 1'b0;
      core_we_i   = 1'b0;
      core_size_i = 3'b000;
      core_addr_i = 32'h0;
      core_wd_i   = 32'h0;
      mem_rd_i    = 32'h0;
      mem_ready_i = 1'b0;

      // Reset state
      #12;
      check_eq("rst_rd",    core_rd_o, 32'h0);
      check_eq("rst_req",   {31'b0, mem_req_o}, 32'h0);
      check_eq("rst_we",    {31'b0, mem_we_o}, 32'h0);
      check_eq("rst_be",    {28'b0, mem_be_o}, 32'h0);
      check_eq("rst_addr",  mem_addr_o, 32'h0);
      check_eq("rst_wd",    mem_wd_o, 32'h0);
      check_eq("rst_err",   {31'b0, lsu_err_o}, 32'h0);
      check_eq("rst_stall", {31'b0, core_stall_o}, 32'h0);
      core_req_i = 1'b1;
      #1;
      check_eq("rst_stall_req", {31'b0, core_stall_o}, 32'h1);
      core_req_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // SB at 0x1003
      run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1);
      check_eq("sb_be",    {28'b0, obs_be}, 32'h8);
      check_eq("sb_wd",    obs_wd, 32'hA5A5_A5A5);
      check_eq("sb_addr",  obs_addr, 32'h0000_1000);
      check_eq("sb_we",    {31'b0, obs_we}, 32'h1);
      check_eq("sb_stall", obs_stall, 2);
      check_eq("sb_reqn",  obs_req, 1);
      check_eq("sb_err",   {31'b0, obs_err}, 32'h0);

      // Loads from 0x80FF7F01
      run_access(1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 1);
      check_eq("lb_rd",   obs_rd, 32'hFFFF_FFFF);
      check_eq("lb_be",   {28'b0, obs_be}, 32'h4);
      check_eq("lb_we",   {31'b0, obs_we}, 32'h0);
      run_access(1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 1);
      check_eq("lbu_rd",  obs_rd, 32'h0000_00FF);
      run_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 1);
      check_eq("lh_rd",   obs_rd, 32'hFFFF_80FF);
      check_eq("lh_be",   {28'b0, obs_be}, 32'hC);
      run_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 1);
      check_eq("lhu_rd",  obs_rd, 32'h0000_80FF);
      run_access(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h80FF_7F01, 1);
      check_eq("lb_pos_rd", obs_rd, 32'h0000_007F);
      run_access(1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h80FF_7F01, 1);
      check_eq("lh_lo_rd",  obs_rd, 32'h0000_7F01);

      // LW with wait states
      run_access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h1234_5678, 5);
      check_eq("lw_wait_stall", obs_stall, 6);
      check_eq("lw_wait_reqn",  obs_req, 5);
      check_eq("lw_wait_rd",    obs_rd, 32'h1234_5678);
      check_eq("lw_wait_err",   {31'b0, obs_err}, 32'h0);

      // Misaligned and illegal-size requests
      run_access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 1);
      check_eq("mis_lw_stall", obs_stall, 1);
      check_eq("mis_lw_reqn",  obs_req, 0);
      check_eq("mis_lw_err",   {31'b0, obs_err}, 32'h1);
      check_eq("mis_lw_rd",    obs_rd, 32'h1234_5678);
      run_access(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1);
      check_eq("ill_sz_stall", obs_stall, 1);
      check_eq("ill_sz_reqn",  obs_req, 0);
      check_eq("ill_sz_err",   {31'b0, obs_err}, 32'h1);
      run_access(1'b1, 3'b001, 32'h0000_4001, 32'h0, 32'h0, 1);
      check_eq("mis_sh_err",   {31'b0, obs_err}, 32'h1);

      // SH leaves core_rd_o alone and clears the error
      run_access(1'b1, 3'b001, 32'h0000_4002, 32'h1234_ABCD, 32'h0, 1);
      check_eq("sh_be",  {28'b0, obs_be}, 32'hC);
      check_eq("sh_wd",  obs_wd, 32'hABCD_ABCD);
      check_eq("sh_err", {31'b0, obs_err}, 32'h0);
      check_eq("sh_rd_kept", obs_rd, 32'h1234_5678);

      // Stray ready while idle is ignored
      @(posedge clk_i); #1;
      mem_rd_i    = 32'h5555_AAAA;
      mem_ready_i = 1'b1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check_eq("idle_ready_req", {31'b0, mem_req_o}, 32'h0);
      check_eq("idle_ready_rd",  core_rd_o, 32'h1234_5678);
      mem_ready_i = 1'b0;

      // Timeout on the TIMEOUT_CYCLES=4 instance
      pulse_reset();
      @(posedge clk_i); #1;
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'b010;
      core_addr_i = 32'h0000_5000;
      to_req_n    = 0;
      to_done     = 1'b0;
      for (int c = 0; c < 20 && !to_done; c++) begin
         @(negedge clk_i);
         if (to_mem_req_o) to_req_n++;
         if (!to_core_stall_o) begin
            to_done = 1'b1;
            check_eq("to_err", {31'b0, to_lsu_err_o}, 32'h1);
         end
      end
      core_req_i = 1'b0;
      check_eq("to_done", {31'b0, to_done}, 32'h1);
      check_eq("to_reqn", to_req_n, 4);
      @(negedge clk_i);
      check_eq("to_idle_req", {31'b0, to_mem_req_o}, 32'h0);
      check_eq("to_err_hold", {31'b0, to_lsu_err_o}, 32'h1);
      // The long-timeout unit keeps its access open after core_req_i drops
      check_eq("long_busy_req", {31'b0, mem_req_o}, 32'h1);

      // Reset in the middle of BUSY
      pulse_reset();
      run_access(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 1);
      check_eq("pre_rst_rd", obs_rd, 32'hCAFE_F00D);
      @(posedge clk_i); #1;
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'b000;
      core_addr_i = 32'h0000_6000;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check_eq("mid_busy_req", {31'b0, mem_req_o}, 32'h1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("async_rst_req", {31'b0, mem_req_o}, 32'h0);
      check_eq("async_rst_rd",  core_rd_o, 32'h0);
      check_eq("async_rst_be",  {28'b0, mem_be_o}, 32'h0);
      core_req_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_access(1'b1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 1);
      check_eq("sw_be",    {28'b0, obs_be}, 32'hF);
      check_eq("sw_wd",    obs_wd, 32'hDEAD_BEEF);
      check_eq("sw_addr",  obs_addr, 32'h0000_7000);
      check_eq("sw_stall", obs_stall, 2);
      check_eq("sw_err",   {31'b0, obs_err}, 32'h0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
